// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl: read-miss block fill sequencer.
// Fetches an 8-word block and streams it into the cache arrays.
module cache_fill_ctrl #(
  parameter int BLOCK_WORDS = 8,
  parameter int ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              mem_data_valid,
  input  logic [15:0]       mem_data,
  output logic              fsm_busy,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              write_data_array,
  output logic              write_tag_array,
  output logic [ADDR_W-1:0] cache_wr_addr,
  output logic [15:0]       cache_wr_data
);

  localparam int OFF_W = $clog2(BLOCK_WORDS);
  localparam logic [OFF_W-1:0] LAST = OFF_W'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [ADDR_W-1:OFF_W]   base_q;
  logic [OFF_W:0]          issue_cnt;
  logic [OFF_W-1:0]        recv_cnt;
  logic                    unused_off;

  // word offset of the miss is replaced by zero when the base is latched
  assign unused_off = ^miss_address[OFF_W-1:0];

  // state, block base and the issue/return counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      base_q    <= '0;
      issue_cnt <= '0;
      recv_cnt  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        if (miss_detected) begin
          base_q    <= miss_address[ADDR_W-1:OFF_W];
          issue_cnt <= '0;
          recv_cnt  <= '0;
        end
      end else begin
        if (!issue_cnt[OFF_W]) begin
          issue_cnt <= issue_cnt + 1'b1;
        end
        if (mem_data_valid) begin
          recv_cnt <= recv_cnt + 1'b1;
        end
      end
    end
  end

  // next state plus request and cache-write outputs
  always_comb begin
    state_d          = state_q;
    fsm_busy         = 1'b0;
    mem_req          = 1'b0;
    mem_addr         = '0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    cache_wr_addr    = '0;
    cache_wr_data    = '0;
    unique case (state_q)
      IDLE: begin
        if (miss_detected) begin
          state_d = FILL;
        end
      end
      FILL: begin
        fsm_busy = 1'b1;
        if (!issue_cnt[OFF_W]) begin
          mem_req  = 1'b1;
          mem_addr = {base_q, issue_cnt[OFF_W-1:0]};
        end
        if (mem_data_valid) begin
          write_data_array = 1'b1;
          cache_wr_addr    = {base_q, recv_cnt};
          cache_wr_data    = mem_data;
          if (recv_cnt == LAST) begin
            write_tag_array = 1'b1;
            state_d         = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// tb_cache_fill_ctrl: scoreboard bench for the miss fill controller.
// Expected cache writes are queued as valids are driven.
module tb_cache_fill_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_address = 16'h0;
  logic        mem_data_valid = 1'b0;
  logic [15:0] mem_data = 16'h0;
  logic        fsm_busy;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        write_data_array;
  logic        write_tag_array;
  logic [15:0] cache_wr_addr;
  logic [15:0] cache_wr_data;

  typedef struct packed {
    logic        tag;
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    int          due;
    logic [15:0] a;
  } req_t;

  wr_t sb[$];
  int  checks = 0;
  int  errors = 0;

  cache_fill_ctrl #(.BLOCK_WORDS(8), .ADDR_W(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .miss_detected    (miss_detected),
    .miss_address     (miss_address),
    .mem_data_valid   (mem_data_valid),
    .mem_data         (mem_data),
    .fsm_busy         (fsm_busy),
    .mem_req          (mem_req),
    .mem_addr         (mem_addr),
    .write_data_array (write_data_array),
    .write_tag_array  (write_tag_array),
    .cache_wr_addr    (cache_wr_addr),
    .cache_wr_data    (cache_wr_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  function automatic logic [51:0] all_out();
    return {fsm_busy, mem_req, mem_addr, write_data_array,
            write_tag_array, cache_wr_addr, cache_wr_data};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] d,
                       input logic [15:0] a, input logic t);
    wr_t w;
    mem_data_valid = v;
    mem_data       = v ? d : 16'h0;
    if (v) begin
      w.tag  = t;
      w.addr = a;
      w.data = d;
      sb.push_back(w);
    end
  endtask

  task automatic start_miss(input logic [15:0] a, input logic hold);
    tick();
    miss_detected  = 1'b1;
    miss_address   = a;
    mem_data_valid = 1'b0;
    tick();
    if (!hold) miss_detected = 1'b0;
  endtask

  task automatic test_reset();
    miss_detected  = 1'b1;
    miss_address   = 16'h1234;
    mem_data_valid = 1'b1;
    #3;
    checks++;
    if (all_out() !== 52'd0) begin
      errors++;
      $display("FAIL reset_outs got %h exp 0", all_out());
    end
    @(negedge clk);
    checks++;
    if (all_out() !== 52'd0) begin
      errors++;
      $display("FAIL reset_hold got %h exp 0", all_out());
    end
    miss_detected  = 1'b0;
    mem_data_valid = 1'b0;
    rst = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (all_out() !== 52'd0) begin
      errors++;
      $display("FAIL reset_idle got %h exp 0", all_out());
    end
  endtask

  task automatic test_basic();
    req_t pend[$];
    req_t r;
    wr_t  exp;
    int   n = 0;
    logic [15:0] ea;
    start_miss(16'h1234, 1'b0);
    for (int c = 1; c <= 14; c++) begin
      if (pend.size() > 0 && pend[0].due == c) begin
        r = pend.pop_front();
        drive(1'b1, 16'hA000 | {13'h0, r.a[2:0]},
              16'h1230 + 16'(n), n == 7);
        n++;
      end else begin
        drive(1'b0, 16'h0, 16'h0, 1'b0);
      end
      @(negedge clk);
      exp = '0;
      if (mem_data_valid && sb.size() > 0) exp = sb.pop_front();
      checks++;
      if ({write_data_array, write_tag_array, cache_wr_addr,
           cache_wr_data} !== {mem_data_valid, exp}) begin
        errors++;
        $display("FAIL basic_wr c=%0d got %b %b %h %h exp %b %h",
                 c, write_data_array, write_tag_array,
                 cache_wr_addr, cache_wr_data, mem_data_valid, exp);
      end
      ea = (c <= 8) ? 16'h1230 + 16'(c - 1) : 16'h0;
      checks++;
      if ({fsm_busy, mem_req, mem_addr} !==
          {(c <= 12), (c <= 8), ea}) begin
        errors++;
        $display("FAIL basic_req c=%0d got %b %b %h exp %b %b %h",
                 c, fsm_busy, mem_req, mem_addr, c <= 12, c <= 8, ea);
      end
      if (mem_req) begin
        r.due = c + 4;
        r.a   = mem_addr;
        pend.push_back(r);
      end
      tick();
    end
    drive(1'b0, 16'h0, 16'h0, 1'b0);
  endtask

  task automatic test_gapped();
    wr_t exp;
    int  n = 0;
    int  gap;
    bit  done = 0;
    gap = $urandom_range(0, 3);
    start_miss(16'h5A5D, 1'b0);
    for (int c = 1; c <= 40 && !done; c++) begin
      if (n < 8 && gap == 0) begin
        drive(1'b1, 16'($urandom), 16'h5A58 + 16'(n), n == 7);
        n++;
        gap = $urandom_range(0, 3);
      end else begin
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        gap--;
      end
      @(negedge clk);
      exp = '0;
      if (mem_data_valid && sb.size() > 0) exp = sb.pop_front();
      checks++;
      if ({write_data_array, write_tag_array, cache_wr_addr,
           cache_wr_data} !== {mem_data_valid, exp}) begin
        errors++;
        $display("FAIL gap_wr c=%0d got %b %b %h %h exp %b %h",
                 c, write_data_array, write_tag_array,
                 cache_wr_addr, cache_wr_data, mem_data_valid, exp);
      end
      checks++;
      if (fsm_busy !== 1'b1) begin
        errors++;
        $display("FAIL gap_busy c=%0d got %b exp 1", c, fsm_busy);
      end
      if (n == 8 && mem_data_valid) done = 1;
      tick();
    end
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    @(negedge clk);
    checks++;
    if (fsm_busy !== 1'b0 || !done) begin
      errors++;
      $display("FAIL gap_end got busy %b done %b exp 0 1",
               fsm_busy, done);
    end
  endtask

  task automatic test_idle_noise();
    for (int c = 0; c < 6; c++) begin
      tick();
      mem_data_valid = c[0] ? 1'b0 : 1'b1;
      mem_data       = 16'($urandom);
      @(negedge clk);
      checks++;
      if (all_out() !== 52'd0) begin
        errors++;
        $display("FAIL idle_noise c=%0d got %h exp 0", c, all_out());
      end
    end
    tick();
    mem_data_valid = 1'b0;
  endtask

  task automatic test_miss_during_fill();
    wr_t exp;
    start_miss(16'h1234, 1'b0);
    for (int c = 1; c <= 14; c++) begin
      miss_detected = (c >= 3 && c <= 12);
      miss_address  = (c >= 3) ? 16'hFFF8 : 16'h1234;
      if (c >= 5 && c <= 12)
        drive(1'b1, 16'hB000 + 16'(c), 16'h1230 + 16'(c - 5), c == 12);
      else
        drive(1'b0, 16'h0, 16'h0, 1'b0);
      @(negedge clk);
      exp = '0;
      if (mem_data_valid && sb.size() > 0) exp = sb.pop_front();
      checks++;
      if ({write_data_array, write_tag_array, cache_wr_addr,
           cache_wr_data} !== {mem_data_valid, exp}) begin
        errors++;
        $display("FAIL mdf_wr c=%0d got %b %b %h %h exp %b %h",
                 c, write_data_array, write_tag_array,
                 cache_wr_addr, cache_wr_data, mem_data_valid, exp);
      end
      checks++;
      if (fsm_busy !== (c <= 12)) begin
        errors++;
        $display("FAIL mdf_busy c=%0d got %b exp %b",
                 c, fsm_busy, c <= 12);
      end
      tick();
    end
    miss_detected = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 1'b0);
  endtask

  task automatic test_reset_mid_fill();
    wr_t exp;
    start_miss(16'h1234, 1'b0);
    for (int c = 1; c <= 5; c++) begin
      drive(c >= 3, 16'hC000 + 16'(c), 16'h1230 + 16'(c - 3), 1'b0);
      @(negedge clk);
      exp = '0;
      if (mem_data_valid && sb.size() > 0) exp = sb.pop_front();
      checks++;
      if ({write_data_array, write_tag_array, cache_wr_addr,
           cache_wr_data} !== {mem_data_valid, exp}) begin
        errors++;
        $display("FAIL rmf_wr c=%0d got %b %b %h %h exp %b %h",
                 c, write_data_array, write_tag_array,
                 cache_wr_addr, cache_wr_data, mem_data_valid, exp);
      end
      tick();
    end
    mem_data_valid = 1'b1;
    mem_data       = 16'hC0FF;
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (all_out() !== 52'd0) begin
      errors++;
      $display("FAIL rmf_async got %h exp 0", all_out());
    end
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    for (int c = 0; c < 5; c++) begin
      tick();
      mem_data_valid = 1'b1;
      mem_data       = 16'hF000 + 16'(c);
      @(negedge clk);
      checks++;
      if (all_out() !== 52'd0) begin
        errors++;
        $display("FAIL rmf_late c=%0d got %h exp 0", c, all_out());
      end
    end
    start_miss(16'h0008, 1'b0);
    for (int c = 1; c <= 9; c++) begin
      if (c <= 8)
        drive(1'b1, 16'hD000 + 16'(c), 16'h0008 + 16'(c - 1), c == 8);
      else
        drive(1'b0, 16'h0, 16'h0, 1'b0);
      @(negedge clk);
      exp = '0;
      if (mem_data_valid && sb.size() > 0) exp = sb.pop_front();
      checks++;
      if ({fsm_busy, write_data_array, write_tag_array, cache_wr_addr,
           cache_wr_data} !== {(c <= 8), mem_data_valid, exp}) begin
        errors++;
        $display("FAIL rmf_refill c=%0d got %b %b %b %h %h exp %b %b %h",
                 c, fsm_busy, write_data_array, write_tag_array,
                 cache_wr_addr, cache_wr_data, c <= 8,
                 mem_data_valid, exp);
      end
      tick();
    end
    drive(1'b0, 16'h0, 16'h0, 1'b0);
  endtask

  task automatic test_back_to_back();
    wr_t  exp;
    int   k;
    logic v;
    logic eb;
    start_miss(16'h2003, 1'b1);
    for (int c = 1; c <= 21; c++) begin
      miss_detected = (c <= 10);
      v = (c >= 2 && c <= 9) || (c >= 12 && c <= 19);
      k = (c >= 12) ? c - 12 : c - 2;
      drive(v, 16'hE000 + 16'(c), 16'h2000 + 16'(k), k == 7);
      @(negedge clk);
      exp = '0;
      if (mem_data_valid && sb.size() > 0) exp = sb.pop_front();
      checks++;
      if ({write_data_array, write_tag_array, cache_wr_addr,
           cache_wr_data} !== {mem_data_valid, exp}) begin
        errors++;
        $display("FAIL b2b_wr c=%0d got %b %b %h %h exp %b %h",
                 c, write_data_array, write_tag_array,
                 cache_wr_addr, cache_wr_data, mem_data_valid, exp);
      end
      eb = (c <= 9) || (c >= 11 && c <= 19);
      checks++;
      if (fsm_busy !== eb) begin
        errors++;
        $display("FAIL b2b_busy c=%0d got %b exp %b", c, fsm_busy, eb);
      end
      if (c == 11) begin
        checks++;
        if ({mem_req, mem_addr} !== {1'b1, 16'h2000}) begin
          errors++;
          $display("FAIL b2b_req got %b %h exp 1 2000",
                   mem_req, mem_addr);
        end
      end
      tick();
    end
    drive(1'b0, 16'h0, 16'h0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_idle_noise();
    test_miss_during_fill();
    test_reset_mid_fill();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
